// File: rtl/rcu_pkg.sv
// rcu_pkg: mesh geometry, port/direction/state enums and hop-sign helper for rcu_multi_port
package rcu_pkg;
  localparam int MESH_WIDTH = 4;
  localparam int MESH_HEIGHT = 4;
  localparam int MESH_DEPTH = 4;
  localparam int CW = 2;
  typedef logic [CW-1:0] coord_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } position_t;
  typedef enum logic [2:0] {LOCAL, EAST, WEST, NORTH, SOUTH, UP, DOWN, DROP} port_t;
  typedef enum logic [1:0] {ZERO, POS, NEG} direction_t;
  typedef enum logic {IDLE, ACTIVE} rcu_state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam coord_t X_MAX = coord_t'(MESH_WIDTH - 1);
  function automatic direction_t hop_dir(coord_t dst, coord_t here);
    logic [CW:0] d;
    d = {1'b0, dst} - {1'b0, here};
    return d == '0 ? ZERO : d[CW] ? NEG : POS;
  endfunction
endpackage

// File: rtl/rcu_multi_port_if.sv
// rcu_multi_port_if: flit/route bundle between input buffers, RCU and allocator; RCU_DROP_CNT_EN adds drop_cnt
interface rcu_multi_port_if import rcu_pkg::*; #(
  parameter int NUM_PORTS = 7
);
  logic [NUM_PORTS-1:0] flit_valid;
  logic [NUM_PORTS-1:0] flit_head;
  logic [NUM_PORTS-1:0] flit_tail;
  logic [NUM_PORTS-1:0] flit_ready;
  position_t [NUM_PORTS-1:0] flit_dest;
  logic up_faulty;
  logic down_faulty;
  logic [NUM_PORTS-1:0] route_valid;
  port_t [NUM_PORTS-1:0] route;
  logic [NUM_PORTS-1:0] proto_err;
`ifdef RCU_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  modport master (
    output flit_valid, flit_head, flit_tail, flit_ready, flit_dest, up_faulty, down_faulty,
    input route_valid, route, proto_err
`ifdef RCU_DROP_CNT_EN
    , input drop_cnt
`endif
  );
  modport slave (
    input flit_valid, flit_head, flit_tail, flit_ready, flit_dest, up_faulty, down_faulty,
    output route_valid, route, proto_err
`ifdef RCU_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/rcu_route_calc.sv
// rcu_route_calc: combinational Z-then-X-then-Y route with X detour around a faulty vertical link
module rcu_route_calc import rcu_pkg::*; #(
  parameter position_t THIS_POS = '0
) (
  input  port_t     inport,
  input  position_t dest,
  input  logic      up_faulty,
  input  logic      down_faulty,
  input  logic      rand_bit,
  output port_t     route
);
  direction_t dx, dy, dz;
  port_t detour;
  logic east_ok, west_ok, z_ok;
  always_comb begin
    dx = hop_dir(dest.x, THIS_POS.x);
    dy = hop_dir(dest.y, THIS_POS.y);
    dz = hop_dir(dest.z, THIS_POS.z);
    east_ok = THIS_POS.x != X_MAX && inport != EAST;
    west_ok = THIS_POS.x != '0 && inport != WEST;
    z_ok = dz == POS ? !up_faulty : !down_faulty;
    detour = east_ok && west_ok ? (rand_bit ? EAST : WEST) : east_ok ? EAST : west_ok ? WEST : DROP;
    route = dz != ZERO ? (z_ok ? (dz == POS ? UP : DOWN) : detour) :
            dx != ZERO ? (dx == POS ? EAST : WEST) :
            dy != ZERO ? (dy == POS ? NORTH : SOUTH) : LOCAL;
  end
endmodule

// File: rtl/rcu_multi_port.sv
// rcu_multi_port: per-port wormhole route holding, LFSR tie-break; RCU_DROP_CNT_EN adds a saturating drop counter
module rcu_multi_port import rcu_pkg::*; #(
  parameter position_t   THIS_POS  = '0,
  parameter int          NUM_PORTS = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  rcu_multi_port_if.slave bus
);
  rcu_state_t [NUM_PORTS-1:0] state_q, state_d;
  port_t [NUM_PORTS-1:0] route_q, route_d, calc;
  logic [NUM_PORTS-1:0] proto_err_q, proto_err_d, head_acc;
  logic [15:0] lfsr_q, lfsr_d;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_calc
    rcu_route_calc #(.THIS_POS(THIS_POS)) u_calc (
      .inport(port_t'(g)),
      .dest(bus.flit_dest[g]),
      .up_faulty(bus.up_faulty),
      .down_faulty(bus.down_faulty),
      .rand_bit(lfsr_q[g % 16]),
      .route(calc[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= IDLE;
        route_q[i] <= LOCAL;
      end
      proto_err_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      proto_err_q <= proto_err_d;
      lfsr_q <= lfsr_d;
    end
  end
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_acc[i] = state_q[i] == IDLE && bus.flit_valid[i] && bus.flit_head[i];
      proto_err_d[i] = state_q[i] == IDLE && bus.flit_valid[i] && !bus.flit_head[i];
      state_d[i] = head_acc[i] ? ACTIVE :
                   (state_q[i] == ACTIVE && bus.flit_valid[i] && bus.flit_ready[i] && bus.flit_tail[i]) ? IDLE :
                   state_q[i];
      route_d[i] = head_acc[i] ? calc[i] : route_q[i];
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) bus.route_valid[i] = state_q[i] == ACTIVE;
  end
  assign bus.route = route_q;
  assign bus.proto_err = proto_err_q;
`ifdef RCU_DROP_CNT_EN
  logic [3:0] drops;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    drops = '0;
    for (int i = 0; i < NUM_PORTS; i++) drops = drops + {3'b0, head_acc[i] && calc[i] == DROP};
    drop_sum = {1'b0, drop_cnt_q} + {13'b0, drops};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule
